// File: rtl/i2c_sched_pkg.sv
// ---------------------------------------------------------------------------
// i2c_sched_pkg
// Shared types and defaults for the I2C message scheduler.
//   sched_state_t       : scheduler FSM states (IDLE, WAIT_DONE, GAP)
//   DEF_GAP_CYCLES      : default guard gap after a transaction (3 ms @ 100 MHz)
//   DEF_TIMEOUT_CYCLES  : default wait limit for i2c_done (100 ms @ 100 MHz)
//   cnt_width()         : width of the shared WAIT_DONE/GAP cycle counter
// ---------------------------------------------------------------------------
package i2c_sched_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        WAIT_DONE = 2'd1,
        GAP       = 2'd2
    } sched_state_t;

    localparam int unsigned DEF_GAP_CYCLES     = 300_000;
    localparam int unsigned DEF_TIMEOUT_CYCLES = 10_000_000;

    // One counter serves both waiting states, so it must hold the larger limit.
    function automatic int unsigned cnt_width(input int unsigned gap_cycles,
                                              input int unsigned timeout_cycles);
        int unsigned max_cycles;
        max_cycles = (gap_cycles > timeout_cycles) ? gap_cycles : timeout_cycles;
        return $clog2(max_cycles + 1);
    endfunction

endpackage

// File: rtl/i2c_msg_scheduler_rr_pick.sv
// ---------------------------------------------------------------------------
// rr_pick
// Combinational round-robin arbiter: finds the first set bit of `pending`
// starting at index `ptr` and wrapping modulo NUM_REQ.
//   pending : request vector (NUM_REQ bits)
//   ptr     : highest-priority index for this search
//   valid   : at least one pending bit is set
//   winner  : index of the selected requester (0 when !valid)
// ---------------------------------------------------------------------------
module rr_pick #(
    parameter  int unsigned NUM_REQ = 3,
    localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] pending,
    input  logic [IDX_W-1:0]   ptr,
    output logic               valid,
    output logic [IDX_W-1:0]   winner
);

    always_comb begin
        int idx;
        // NOTE: every output of a combinational block gets a default first,
        // so no path through the block can leave it unassigned (no latch).
        valid  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int k = 0; k < int'(NUM_REQ); k++) begin
            // ptr + k is below 2*NUM_REQ, so one conditional subtract wraps it.
            idx = int'(ptr) + k;
            if (idx >= int'(NUM_REQ)) begin
                idx = idx - int'(NUM_REQ);
            end
            if (!valid && pending[idx[IDX_W-1:0]]) begin
                valid  = 1'b1;
                winner = idx[IDX_W-1:0];
            end
        end
    end

endmodule

// File: rtl/i2c_msg_scheduler.sv
// ---------------------------------------------------------------------------
// i2c_msg_scheduler
// Shares one I2C display master among NUM_REQ message sources. Request pulses
// and payloads are latched, granted round-robin one at a time, and each
// transaction is followed by a guard gap of GAP_CYCLES idle cycles.
//   clk, rst_n  : clock, asynchronous active-low reset
//   req         : per-requester 1-clk request pulse
//   req_data    : payloads, slice i belongs to req[i]
//   i2c_done    : master completion pulse (ignored outside WAIT_DONE)
//   err_clr     : clears timeout_err (a coincident new timeout wins)
//   i2c_start   : 1-clk launch pulse to the master
//   i2c_data    : granted payload, held until the next grant
//   i2c_src     : granted requester index, held until the next grant
//   busy        : FSM not in IDLE
//   pending     : latched, not-yet-issued requests
//   served      : 1-clk pulse for the requester whose transaction ended
//   timeout_err : sticky flag, set when i2c_done never arrived
// ---------------------------------------------------------------------------
module i2c_msg_scheduler
    import i2c_sched_pkg::*;
#(
    parameter  int unsigned NUM_REQ        = 3,
    parameter  int unsigned DATA_W         = 8,
    parameter  int unsigned GAP_CYCLES     = DEF_GAP_CYCLES,
    parameter  int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES,
    localparam int unsigned IDX_W          = $clog2(NUM_REQ)
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [NUM_REQ-1:0]        req,
    input  logic [NUM_REQ*DATA_W-1:0] req_data,
    input  logic                      i2c_done,
    input  logic                      err_clr,
    output logic                      i2c_start,
    output logic [DATA_W-1:0]         i2c_data,
    output logic [IDX_W-1:0]          i2c_src,
    output logic                      busy,
    output logic [NUM_REQ-1:0]        pending,
    output logic [NUM_REQ-1:0]        served,
    output logic                      timeout_err
);

    localparam int unsigned CNT_W = cnt_width(GAP_CYCLES, TIMEOUT_CYCLES);

    sched_state_t      state;
    sched_state_t      state_nxt;
    logic [CNT_W-1:0]  cnt;
    logic [IDX_W-1:0]  ptr;
    logic [IDX_W-1:0]  pick_idx;
    logic              pick_valid;
    logic              cnt_at_tmo;
    logic              cnt_at_gap;
    logic              grant;
    logic              txn_end;
    logic              tmo_hit;
    logic [DATA_W-1:0] payload [NUM_REQ];

    rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_rr_pick (
        .pending (pending),
        .ptr     (ptr),
        .valid   (pick_valid),
        .winner  (pick_idx)
    );

    assign cnt_at_tmo = (cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    assign cnt_at_gap = (cnt == CNT_W'(GAP_CYCLES - 1));

    // ---------------- state register ----------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: clocked state uses non-blocking assignments so every register
        // samples pre-edge values regardless of block evaluation order.
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // ---------------- next-state logic ----------------
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:      if (pick_valid)             state_nxt = WAIT_DONE;
            WAIT_DONE: if (i2c_done || cnt_at_tmo) state_nxt = GAP;
            GAP:       if (cnt_at_gap)             state_nxt = IDLE;
            default:                               state_nxt = IDLE;
        endcase
    end

    // ---------------- output / event decode ----------------
    always_comb begin
        grant   = 1'b0;
        txn_end = 1'b0;
        tmo_hit = 1'b0;
        busy    = (state != IDLE);
        case (state)
            IDLE:      grant = pick_valid;
            WAIT_DONE: begin
                txn_end = i2c_done || cnt_at_tmo;
                // done in the final cycle still counts as a clean completion
                tmo_hit = cnt_at_tmo && !i2c_done;
            end
            default: ;
        endcase
    end

    // Shared cycle counter: zero on every state entry, idle in IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if ((state_nxt != state) || (state == IDLE)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    // Request capture and round-robin pointer. The set is written after the
    // grant clear so a request arriving on its own grant edge stays pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pending <= '0;
            ptr     <= '0;
            // NOTE: the payload array is cleared on reset as well, so a
            // grant can never expose stale data from before the reset.
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                payload[i] <= '0;
            end
        end else begin
            if (grant) begin
                pending[pick_idx] <= 1'b0;
                ptr <= (pick_idx == IDX_W'(NUM_REQ - 1)) ? '0 : pick_idx + 1'b1;
            end
            for (int i = 0; i < int'(NUM_REQ); i++) begin
                if (req[i]) begin
                    pending[i] <= 1'b1;
                    payload[i] <= req_data[i*DATA_W +: DATA_W];
                end
            end
        end
    end

    // Master-facing registers and status flags.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            i2c_start   <= 1'b0;
            i2c_data    <= '0;
            i2c_src     <= '0;
            served      <= '0;
            timeout_err <= 1'b0;
        end else begin
            i2c_start <= grant;
            served    <= '0;
            if (grant) begin
                i2c_data <= payload[pick_idx];
                i2c_src  <= pick_idx;
            end
            if (txn_end) begin
                served[i2c_src] <= 1'b1;
            end
            if (tmo_hit) begin
                timeout_err <= 1'b1;
            end else if (err_clr) begin
                timeout_err <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_i2c_msg_scheduler.sv
module tb_i2c_msg_scheduler;

    localparam int NUM_REQ = 3;
    localparam int DATA_W  = 8;
    localparam int GAP     = 4;
    localparam int TMO     = 20;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic [2:0]  req = '0;
    logic [23:0] req_data = '0;
    logic        i2c_done = 1'b0;
    logic        err_clr = 1'b0;
    logic        i2c_start;
    logic [7:0]  i2c_data;
    logic [1:0]  i2c_src;
    logic        busy;
    logic [2:0]  pending;
    logic [2:0]  served;
    logic        timeout_err;

    always #5 clk = ~clk;

    i2c_msg_scheduler #(
        .NUM_REQ        (NUM_REQ),
        .DATA_W         (DATA_W),
        .GAP_CYCLES     (GAP),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req         (req),
        .req_data    (req_data),
        .i2c_done    (i2c_done),
        .err_clr     (err_clr),
        .i2c_start   (i2c_start),
        .i2c_data    (i2c_data),
        .i2c_src     (i2c_src),
        .busy        (busy),
        .pending     (pending),
        .served      (served),
        .timeout_err (timeout_err)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // ---------------- reference model (timestamp based) ----------------
    // The scheduler is described by when things happen: a transaction that
    // was granted at edge G ends on the first done, or at edge G+TMO; after
    // it ends at edge D the block is idle again from edge D+GAP onward.
    logic [2:0] m_pend;
    logic [7:0] m_pay [3];
    int         m_ptr;
    bit         m_in_txn;
    int         m_grant_edge;
    int         m_idle_edge;
    int         edge_n = 0;

    logic       e_start;
    logic [7:0] e_data;
    logic [1:0] e_src;
    logic       e_busy;
    logic [2:0] e_served;
    logic       e_err;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (edge %0d)", name, act, exp, edge_n);
        end
    endtask

    task automatic model_reset();
        m_pend       = '0;
        for (int i = 0; i < 3; i++) m_pay[i] = '0;
        m_ptr        = 0;
        m_in_txn     = 1'b0;
        m_grant_edge = 0;
        m_idle_edge  = edge_n;
        e_start      = 1'b0;
        e_data       = '0;
        e_src        = '0;
        e_busy       = 1'b0;
        e_served     = '0;
        e_err        = 1'b0;
    endtask

    task automatic model_step(input logic [2:0] r, input logic [23:0] d,
                              input logic dn, input logic ec);
        bit new_tmo;
        int win;
        int idx;
        edge_n++;
        new_tmo  = 1'b0;
        e_start  = 1'b0;
        e_served = '0;
        if (m_in_txn) begin
            if (dn || (edge_n == m_grant_edge + TMO)) begin
                new_tmo          = !dn;
                e_served[e_src]  = 1'b1;
                m_in_txn         = 1'b0;
                m_idle_edge      = edge_n + GAP;
            end
        end else if ((edge_n > m_idle_edge) && (m_pend != 0)) begin
            win = -1;
            for (int k = 0; k < 3; k++) begin
                idx = (m_ptr + k) % 3;
                if (win < 0 && m_pend[2'(idx)]) win = idx;
            end
            e_start          = 1'b1;
            e_src            = 2'(win);
            e_data           = m_pay[2'(win)];
            m_pend[2'(win)]  = 1'b0;
            m_ptr            = (win + 1) % 3;
            m_in_txn         = 1'b1;
            m_grant_edge     = edge_n;
        end
        for (int i = 0; i < 3; i++) begin
            if (r[i]) begin
                m_pend[i] = 1'b1;
                m_pay[i]  = d[i*8 +: 8];
            end
        end
        if (new_tmo) e_err = 1'b1;
        else if (ec) e_err = 1'b0;
        e_busy = m_in_txn || (edge_n < m_idle_edge);
    endtask

    task automatic compare_all();
        check("i2c_start",   i2c_start,   e_start);
        check("i2c_data",    i2c_data,    e_data);
        check("i2c_src",     i2c_src,     e_src);
        check("busy",        busy,        e_busy);
        check("pending",     pending,     m_pend);
        check("served",      served,      e_served);
        check("timeout_err", timeout_err, e_err);
    endtask

    // One clock cycle: drive, let the edge happen, advance the model, compare.
    task automatic cyc(input logic [2:0] r, input logic [23:0] d,
                       input logic dn, input logic ec);
        req      = r;
        req_data = d;
        i2c_done = dn;
        err_clr  = ec;
        @(posedge clk);
        model_step(r, d, dn, ec);
        #1;
        compare_all();
    endtask

    task automatic do_reset();
        req      = '0;
        req_data = '0;
        i2c_done = 1'b0;
        err_clr  = 1'b0;
        rst_n    = 1'b0;
        model_reset();
        #1;
        compare_all();
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic wait_start(input int src_v, input logic [7:0] data_v, output int at_edge);
        int n;
        n = 0;
        while (i2c_start !== 1'b1 && n < 60) begin
            cyc('0, '0, 1'b0, 1'b0);
            n++;
        end
        check("start_within_bound", 32'(n < 60), 32'd1);
        check("grant_src", i2c_src, src_v);
        check("grant_data", i2c_data, data_v);
        at_edge = edge_n;
    endtask

    task automatic finish_txn(input int k);
        repeat (k) cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while (busy !== 1'b0 && n < 60) begin
            cyc('0, '0, 1'b0, 1'b0);
            n++;
        end
        check("idle_within_bound", 32'(n < 60), 32'd1);
    endtask

    // ---------------- vector table: single request ----------------
    typedef struct {
        logic [2:0] req;
        logic [7:0] d1;
        logic       done;
        logic       start;
        logic [1:0] src;
        logic [7:0] data;
        logic       busy;
        logic [2:0] pend;
        logic [2:0] served;
    } vec_t;

    vec_t tbl [12];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    initial begin
        int e0, e1, e2;
        logic [2:0]  r;
        logic [23:0] d;
        logic        dn, ec;

        tbl[0]  = '{3'b010, 8'h5A, 1'b0, 1'b0, 2'd0, 8'h00, 1'b0, 3'b010, 3'b000};
        tbl[1]  = '{3'b000, 8'h00, 1'b0, 1'b1, 2'd1, 8'h5A, 1'b1, 3'b000, 3'b000};
        for (int i = 2; i <= 6; i++)
            tbl[i] = '{3'b000, 8'h00, 1'b0, 1'b0, 2'd1, 8'h5A, 1'b1, 3'b000, 3'b000};
        tbl[7]  = '{3'b000, 8'h00, 1'b1, 1'b0, 2'd1, 8'h5A, 1'b1, 3'b000, 3'b010};
        for (int i = 8; i <= 10; i++)
            tbl[i] = '{3'b000, 8'h00, 1'b0, 1'b0, 2'd1, 8'h5A, 1'b1, 3'b000, 3'b000};
        tbl[11] = '{3'b000, 8'h00, 1'b0, 1'b0, 2'd1, 8'h5A, 1'b0, 3'b000, 3'b000};

        #2;
        do_reset();

        // Single request: start two edges after req, done 6 cycles later,
        // busy drops exactly GAP cycles after done.
        for (int i = 0; i < 12; i++) begin
            cyc(tbl[i].req, {8'h00, tbl[i].d1, 8'h00}, tbl[i].done, 1'b0);
            check($sformatf("tbl%0d_start", i),  i2c_start, tbl[i].start);
            check($sformatf("tbl%0d_src", i),    i2c_src,   tbl[i].src);
            check($sformatf("tbl%0d_data", i),   i2c_data,  tbl[i].data);
            check($sformatf("tbl%0d_busy", i),   busy,      tbl[i].busy);
            check($sformatf("tbl%0d_pend", i),   pending,   tbl[i].pend);
            check($sformatf("tbl%0d_served", i), served,    tbl[i].served);
        end

        // Round-robin from a fresh pointer.
        do_reset();
        cyc(3'b111, {8'h12, 8'h11, 8'h10}, 1'b0, 1'b0);
        wait_start(0, 8'h10, e0);
        finish_txn(3);
        wait_start(1, 8'h11, e1);
        check("rr_spacing_01", 32'((e1 - e0) >= 9), 32'd1);
        finish_txn(3);
        wait_start(2, 8'h12, e2);
        check("rr_spacing_12", 32'((e2 - e1) >= 9), 32'd1);
        finish_txn(3);
        wait_idle();
        cyc(3'b101, {8'hC2, 8'h00, 8'hC0}, 1'b0, 1'b0);
        wait_start(0, 8'hC0, e0);
        finish_txn(3);
        wait_start(2, 8'hC2, e0);
        finish_txn(3);
        wait_idle();

        // Overwrite while busy: latest payload wins, single transaction.
        cyc(3'b001, {8'h00, 8'h00, 8'h30}, 1'b0, 1'b0);
        wait_start(0, 8'h30, e0);
        cyc(3'b010, {8'h00, 8'h21, 8'h00}, 1'b0, 1'b0);
        cyc(3'b010, {8'h00, 8'h22, 8'h00}, 1'b0, 1'b0);
        check("ovw_pending", pending, 3'b010);
        finish_txn(3);
        wait_start(1, 8'h22, e0);
        check("ovw_pending_cleared", pending, 3'b000);
        finish_txn(2);
        wait_idle();
        repeat (8) cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);   // stray done while IDLE
        check("stray_done_served", served, 3'b000);

        // Collision: new req[2] on the edge its older message is granted.
        cyc(3'b100, {8'h40, 8'h00, 8'h00}, 1'b0, 1'b0);
        cyc(3'b100, {8'h41, 8'h00, 8'h00}, 1'b0, 1'b0);
        check("coll_start", i2c_start, 1'b1);
        check("coll_src", i2c_src, 2'd2);
        check("coll_data", i2c_data, 8'h40);
        check("coll_pending", pending, 3'b100);
        finish_txn(3);
        wait_start(2, 8'h41, e0);
        finish_txn(3);
        wait_idle();

        // Timeout, then clear; done on the last cycle; clear vs set.
        cyc(3'b001, {8'h00, 8'h00, 8'h77}, 1'b0, 1'b0);
        wait_start(0, 8'h77, e0);
        repeat (TMO - 1) cyc('0, '0, 1'b0, 1'b0);
        check("tmo_not_yet", timeout_err, 1'b0);
        cyc('0, '0, 1'b0, 1'b0);
        check("tmo_set", timeout_err, 1'b1);
        check("tmo_served", served, 3'b001);
        repeat (GAP) cyc('0, '0, 1'b0, 1'b0);
        check("tmo_gap_done", busy, 1'b0);
        cyc('0, '0, 1'b0, 1'b1);
        check("err_clr", timeout_err, 1'b0);

        cyc(3'b001, {8'h00, 8'h00, 8'h78}, 1'b0, 1'b0);
        wait_start(0, 8'h78, e0);
        repeat (TMO - 1) cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b1, 1'b0);
        check("done_at_tmo_err", timeout_err, 1'b0);
        check("done_at_tmo_served", served, 3'b001);
        wait_idle();

        cyc(3'b001, {8'h00, 8'h00, 8'h79}, 1'b0, 1'b0);
        wait_start(0, 8'h79, e0);
        repeat (TMO - 1) cyc('0, '0, 1'b0, 1'b0);
        cyc('0, '0, 1'b0, 1'b1);
        check("tmo_beats_clr", timeout_err, 1'b1);
        wait_idle();
        cyc('0, '0, 1'b0, 1'b1);

        // Reset in WAIT_DONE with two requests still pending.
        cyc(3'b001, {8'h00, 8'h00, 8'h55}, 1'b0, 1'b0);
        wait_start(0, 8'h55, e0);
        cyc(3'b110, {8'h66, 8'h65, 8'h00}, 1'b0, 1'b0);
        check("rst_pre_pending", pending, 3'b110);
        #3;
        do_reset();
        repeat (10) cyc('0, '0, 1'b0, 1'b0);
        cyc(3'b010, {8'h00, 8'h33, 8'h00}, 1'b0, 1'b0);
        wait_start(1, 8'h33, e0);
        finish_txn(2);
        wait_idle();

        // Randomized traffic against the model.
        for (int c = 0; c < 800; c++) begin
            r[0] = ($urandom_range(0, 5) == 0);
            r[1] = ($urandom_range(0, 5) == 0);
            r[2] = ($urandom_range(0, 5) == 0);
            d    = 24'($urandom);
            dn   = m_in_txn ? ($urandom_range(0, 9) == 0) : ($urandom_range(0, 15) == 0);
            ec   = ($urandom_range(0, 15) == 0);
            cyc(r, d, dn, ec);
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/i2c_msg_scheduler.md
Name: i2c_msg_scheduler

Overview:
- Shares the single I2C display master among several message requesters: play FSM score update, victory tracker result, and the restart/idle banner.
- Latches 1-clk request pulses plus payload, and grants round-robin.
- Issues one transaction at a time and waits for the master's done.
- Enforces a guard gap between transactions, so callers no longer need local 3 ms delay counters.
- Sits between the game FSMs and the I2C master.

Parameters:
- NUM_REQ, 3, number of requesters (2..8)
- DATA_W, 8, payload width per message
- GAP_CYCLES, 300_000, idle guard cycles after each transaction (3 ms @ 100 MHz)
- TIMEOUT_CYCLES, 10_000_000, max cycles to wait for i2c_done (100 ms)

Ports:
- clk  in  1  system clock, 100 MHz
- rst_n  in  1  reset
- req  in  NUM_REQ  per-requester 1-clk request pulse
- req_data  in  NUM_REQ*DATA_W  payloads; slice i belongs to req[i]
- i2c_done  in  1  master completion pulse
- err_clr  in  1  clears timeout_err
- i2c_start  out  1  1-clk launch pulse to master
- i2c_data  out  DATA_W  payload of the granted message; stable from i2c_start until done or timeout
- i2c_src  out  $clog2(NUM_REQ)  index of the granted requester
- busy  out  1  high in any state other than IDLE
- pending  out  NUM_REQ  latched, not-yet-issued requests
- served  out  NUM_REQ  1-clk pulse on the bit of the requester whose transaction completed or timed out
- timeout_err  out  1  sticky timeout flag

Interface (already decided): one clock; reset is asynchronous and active-low.

Behaviour:
- Reset values: all outputs 0; rr pointer = 0; all pending and payload registers cleared; state IDLE.
- Reset asserted mid-transaction:
  - Everything is cleared immediately.
  - No further i2c_start is issued.
  - The master is expected to be reset by the same rst_n.
- Capture:
  - req[i] sampled high at an edge sets pending[i] and stores req_data slice i.
  - If pending[i] is already set, the payload is overwritten (latest wins) and pending stays set.
- States:
  - IDLE: if any pending bit is set, select the winner round-robin.
    - Search starts at ptr and wraps modulo NUM_REQ.
    - Load i2c_data/i2c_src from the winner.
    - Clear pending[winner] and pulse i2c_start.
    - Go to WAIT_DONE.
    - Set ptr = winner+1 mod NUM_REQ.
  - WAIT_DONE: count cycles.
    - On i2c_done: pulse served[src] and go to GAP.
    - If the count reaches TIMEOUT_CYCLES-1 without done: set timeout_err, pulse served[src], go to GAP.
    - If done and timeout occur in the same cycle, done wins and timeout_err is not set.
  - GAP: count GAP_CYCLES cycles, then go to IDLE. Requests keep latching during GAP.
- Latency:
  - req sampled at edge E → pending visible after E.
  - i2c_start is high for the cycle after edge E+1, provided the FSM is IDLE.
  - Minimum spacing between consecutive i2c_start pulses is 2 + GAP_CYCLES cycles plus the transaction time.
- Simultaneous events:
  - req[i] in the same cycle its older message is granted: the pending clear and the new set collide. Set wins, so the new payload remains pending for a later grant.
  - i2c_done outside WAIT_DONE is ignored.
  - err_clr and a new timeout in the same cycle: set wins.
- Counters: a single shared counter reused by WAIT_DONE and GAP. Width is $clog2(max(GAP_CYCLES, TIMEOUT_CYCLES)+1). It resets to 0 on every state entry.
- i2c_data and i2c_src hold their last values in GAP and IDLE until the next grant.

Decomposition:
- Package i2c_sched_pkg holds:
  - the state enum (IDLE, WAIT_DONE, GAP)
  - default localparams for GAP_CYCLES and TIMEOUT_CYCLES
  - a function for the counter width
- One sub-module, rr_pick:
  - combinational round-robin winner from pending and ptr
  - outputs a valid flag and the winner index
  - unit-testable in isolation

Test Plan (all scenarios use GAP_CYCLES=4, TIMEOUT_CYCLES=20, NUM_REQ=3):
- Single request:
  - Stimulus: req[1] pulse with data 0x5A.
  - Response: i2c_start two edges later with i2c_data=0x5A, i2c_src=1.
  - Then i2c_done after 6 cycles → served[1] pulse; busy falls exactly 4 cycles after done.
- Round-robin:
  - Stimulus: req[0], req[1], req[2] in the same cycle (0x10, 0x11, 0x12); done each after 3 cycles.
  - Response: grant order 0,1,2; consecutive i2c_start pulses spaced ≥ 2+4+3 cycles.
  - Then req[0] and req[2] together → 0 granted first (ptr=0 after wrap).
- Overwrite:
  - Stimulus: while busy on req 0, req[1] with 0x21, then req[1] with 0x22.
  - Response: one transaction for src 1 carrying 0x22; pending[1] cleared after the grant.
- Collision:
  - Stimulus: req[2] pulse in the same cycle its earlier message is granted.
  - Response: pending[2] stays 1; a second src 2 transaction follows with the new data.
- Timeout:
  - Stimulus: no i2c_done after the grant.
  - Response: timeout_err rises after 20 cycles in WAIT_DONE, with a served pulse, then GAP → IDLE.
  - Then err_clr → timeout_err 0; a done coincident with the final timeout cycle leaves timeout_err 0.
- Reset mid-operation:
  - Stimulus: assert rst_n low during WAIT_DONE with pending=3'b110.
  - Response: all outputs 0 immediately; no i2c_start after release until a new req arrives.
